upsample_mc: RTL

Multi-channel, run-time configurable integer upsampler for the CIC interpolator input path. It replaces the fixed-factor, single-channel zero-insertion shift register with a slot counter that holds one sample per channel for L output slots. It emits the held sample on a selectable phase slot and either zero-inserts or zero-order-holds on the remaining slots. Factor, phase and mode are re-latched at every frame start, so the rate can change on the fly without glitches.

---
 rtl/upsample_mc.sv | 105 ++++++++++
 1 files changed

// File: rtl/upsample_mc.sv
// Multi-channel run-time configurable integer upsampler: holds one sample per channel
// for L output slots, emitting it on a selectable phase slot with zero insertion or zero-order hold.
module upsample_mc #(
    parameter  int gp_data_width  = 8,
    parameter  int gp_nr_channels = 2,
    parameter  int gp_max_factor  = 16,
    localparam int c_fw           = $clog2(gp_max_factor + 1),
    localparam int c_dw           = gp_nr_channels * gp_data_width
) (
    input  logic            i_clk,
    input  logic            i_rst_an,
    input  logic            i_ena,
    input  logic            i_sync,
    input  logic [c_fw-1:0] i_factor,
    input  logic [c_fw-1:0] i_phase,
    input  logic            i_mode,
    input  logic [c_dw-1:0] i_data,
    output logic [c_dw-1:0] o_data,
    output logic            o_valid,
    output logic            o_load,
    output logic            o_shift_done
);

    localparam logic [c_fw-1:0] c_one = c_fw'(1);
    localparam logic [c_fw-1:0] c_max = c_fw'(gp_max_factor);

    logic [c_fw-1:0] r_slot;
    logic [c_fw-1:0] r_factor;
    logic [c_fw-1:0] r_phase;
    logic            r_mode;
    logic [c_dw-1:0] r_hold;

    logic            w_start;
    logic [c_fw-1:0] w_fac_cl;
    logic [c_fw-1:0] w_ph_cl;
    logic [c_fw-1:0] w_fac;
    logic [c_fw-1:0] w_ph;
    logic            w_mode;
    logic [c_fw-1:0] w_s;
    logic [c_fw-1:0] w_slot_nxt;
    logic [c_dw-1:0] w_cur;

    assign w_start = i_ena & ((r_slot == '0) | i_sync);
    assign o_load  = w_start;

    // On a frame-start edge the freshly clamped controls govern that very slot.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_fac_cl = i_factor;
        if (i_factor == '0)
            w_fac_cl = c_one;
        else if (i_factor > c_max)
            w_fac_cl = c_max;

        w_ph_cl = i_phase;
        if (i_phase >= w_fac_cl)
            w_ph_cl = w_fac_cl - c_one;

        w_fac  = w_start ? w_fac_cl : r_factor;
        w_ph   = w_start ? w_ph_cl  : r_phase;
        w_mode = w_start ? i_mode   : r_mode;
        w_s    = w_start ? '0       : r_slot;
        w_cur  = w_start ? i_data   : r_hold;

        w_slot_nxt = r_slot + c_one;
        if (w_start)
            w_slot_nxt = (w_fac_cl == c_one) ? '0 : c_one;
        else if (r_slot == r_factor - c_one)
            w_slot_nxt = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: r_hold is a plain register bank, so it is reset with everything else.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_slot       <= '0;
            r_factor     <= c_one;
            r_phase      <= '0;
            r_mode       <= 1'b0;
            r_hold       <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_shift_done <= 1'b0;
        end else if (i_ena) begin
            r_slot <= w_slot_nxt;
            if (w_start) begin
                r_hold   <= i_data;
                r_factor <= w_fac_cl;
                r_phase  <= w_ph_cl;
                r_mode   <= i_mode;
            end
            if (w_s == w_ph) begin
                o_data  <= w_cur;
                o_valid <= 1'b1;
            end else begin
                o_valid <= 1'b0;
                if (!w_mode)
                    o_data <= '0;
            end
            if (w_s == w_fac - c_one)
                o_shift_done <= 1'b1;
        end
    end

endmodule
